// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  localparam logic [XLEN-1:0] DIVZ_Q  = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/muldiv_special.sv
// Detects divide-by-zero and signed overflow, which finish without the datapath.
module muldiv_special
  import muldiv_pkg::*;
(
  input  logic            is_div,
  input  logic            is_rem,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            special_c,
  output logic [XLEN-1:0] result_c
);

  always_comb begin
    special_c = 1'b0;
    result_c  = '0;
    if (is_div) begin
      if (rs2 == '0) begin
        special_c = 1'b1;
        result_c  = is_rem ? rs1 : DIVZ_Q;
      end else if (!is_unsigned && (rs1 == INT_MIN) && (rs2 == '1)) begin
        special_c = 1'b1;
        result_c  = is_rem ? '0 : INT_MIN;
      end
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared iterative mul/div datapath: start, step count,
// result capture and the decode-release handshakes.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 33,
  parameter int unsigned DIV_CYCLES = 33
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        hold,
  input  logic        kill,
  input  logic        issue_valid,
  input  logic        issue_is_div,
  input  logic [2:0]  issue_funct3,
  input  logic [31:0] issue_rs1,
  input  logic [31:0] issue_rs2,
  output logic        dp_start,
  output logic        dp_step,
  output logic        dp_is_div,
  output logic [2:0]  dp_funct3,
  output logic [31:0] dp_a,
  output logic [31:0] dp_b,
  input  logic [31:0] dp_result,
  output logic        mul_ready,
  output logic        div_ready,
  output logic [31:0] mulres,
  output logic [31:0] divres,
  output logic        busy
);

  localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      mulres_q, mulres_d;
  logic [31:0]      divres_q, divres_d;

  logic             accept;
  logic             special_c;
  logic [31:0]      special_res_c;

  muldiv_special u_special (
    .is_div      (issue_is_div),
    .is_rem      (issue_funct3[1]),
    .is_unsigned (issue_funct3[0]),
    .rs1         (issue_rs1),
    .rs2         (issue_rs2),
    .special_c   (special_c),
    .result_c    (special_res_c)
  );

  always_ff @(posedge clk) begin
    if (!Rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      funct3_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mulres_q <= '0;
      divres_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      funct3_q <= funct3_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mulres_q <= mulres_d;
      divres_q <= divres_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    funct3_d  = funct3_q;
    a_d       = a_q;
    b_d       = b_q;
    mulres_d  = mulres_q;
    divres_d  = divres_q;
    accept    = 1'b0;
    dp_start  = 1'b0;
    dp_step   = 1'b0;
    dp_is_div = is_div_q;
    dp_funct3 = funct3_q;
    dp_a      = a_q;
    dp_b      = b_q;

    case (state_q)
      IDLE: begin
        dp_is_div = issue_is_div;
        dp_funct3 = issue_funct3;
        accept    = issue_valid & ~hold & ~kill;
        if (accept) begin
          is_div_d = issue_is_div;
          funct3_d = issue_funct3;
          if (special_c) begin
            divres_d = special_res_c;
            state_d  = DONE;
          end else begin
            dp_start = 1'b1;
            dp_a     = issue_rs1;
            dp_b     = issue_rs2;
            a_d      = issue_rs1;
            b_d      = issue_rs2;
            cnt_d    = issue_is_div ? DIV_LOAD : MUL_LOAD;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        if (!hold && !kill) begin
          dp_step = 1'b1;
          if (cnt_q == '0) begin
            if (is_div_q) divres_d = dp_result;
            else          mulres_d = dp_result;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (!hold) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush wins over everything, including a frozen pipeline.
    if (kill) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  assign mul_ready = (state_q == DONE) & ~is_div_q;
  assign div_ready = (state_q == DONE) &  is_div_q;
  assign busy      = (state_q != IDLE);
  assign mulres    = mulres_q;
  assign divres    = divres_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl with a behavioural datapath model.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int N = 33;

  logic        clk = 1'b0;
  logic        Rst;
  logic        hold, kill, issue_valid, issue_is_div;
  logic [2:0]  issue_funct3;
  logic [31:0] issue_rs1, issue_rs2;
  logic        dp_start, dp_step, dp_is_div;
  logic [2:0]  dp_funct3;
  logic [31:0] dp_a, dp_b, dp_result;
  logic        mul_ready, div_ready, busy;
  logic [31:0] mulres, divres;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        is_div;
    logic [31:0] res;
  } exp_t;
  exp_t sb[$];

  logic [31:0] exp_mulres = '0;
  logic [31:0] exp_divres = '0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_CYCLES(N), .DIV_CYCLES(N)) dut (
    .clk(clk), .Rst(Rst), .hold(hold), .kill(kill),
    .issue_valid(issue_valid), .issue_is_div(issue_is_div),
    .issue_funct3(issue_funct3), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .dp_start(dp_start), .dp_step(dp_step), .dp_is_div(dp_is_div),
    .dp_funct3(dp_funct3), .dp_a(dp_a), .dp_b(dp_b), .dp_result(dp_result),
    .mul_ready(mul_ready), .div_ready(div_ready),
    .mulres(mulres), .divres(divres), .busy(busy)
  );

  function automatic logic [31:0] ref_calc(input logic d, input logic [2:0] f,
                                           input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    if (!d) begin
      ea = (f == MULHU) ? {32'b0, a} : {{32{a[31]}}, a};
      eb = (f == MULH)  ? {{32{b[31]}}, b} : {32'b0, b};
      p  = ea * eb;
      return (f == MUL) ? p[31:0] : p[63:32];
    end
    if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : 32'h8000_0000;
    case (f)
      DIV:     return 32'($signed(a) / $signed(b));
      DIVU:    return a / b;
      REM:     return 32'($signed(a) % $signed(b));
      default: return a % b;
    endcase
  endfunction

  // Datapath model: result is a pure function of the operands loaded on dp_start.
  logic        mdl_div;
  logic [2:0]  mdl_f3;
  logic [31:0] mdl_a, mdl_b;
  always @(posedge clk) begin
    if (dp_start) begin
      mdl_div <= dp_is_div;
      mdl_f3  <= dp_funct3;
      mdl_a   <= dp_a;
      mdl_b   <= dp_b;
    end
  end
  assign dp_result = ref_calc(mdl_div, mdl_f3, mdl_a, mdl_b);

  // Called at #1 after a posedge; returns at #1 after the DONE-exit edge.
  task automatic run_op(input string name, input logic d, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_res,
                        input int hold_at, input int hold_len, input int exp_lat,
                        input int exp_starts, input int exp_steps, input int exp_rdy,
                        output int starts);
    int   steps, rdy;
    logic done;
    exp_t e;
    starts = 0; steps = 0; rdy = 0; done = 1'b0;
    issue_valid = 1'b1; issue_is_div = d; issue_funct3 = f;
    issue_rs1 = a; issue_rs2 = b;
    sb.push_back('{d, exp_res});
    for (int c = 0; c < 300; c++) begin
      hold = (hold_len > 0) && (c >= hold_at) && (c < hold_at + hold_len);
      @(negedge clk);
      starts += int'(dp_start);
      steps  += int'(dp_step);
      if (c == 0 && exp_starts > 0) begin
        n_cmp++;
        if (dp_a !== a || dp_b !== b) begin
          n_err++;
          $display("FAIL %s operands: got a=%h b=%h, want a=%h b=%h", name, dp_a, dp_b, a, b);
        end
      end
      if (mul_ready | div_ready) begin
        if (rdy == 0) begin
          e = sb.pop_front();
          n_cmp++;
          if (c !== exp_lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d, want %0d", name, c, exp_lat);
          end
          n_cmp++;
          if (mul_ready !== !e.is_div || div_ready !== e.is_div) begin
            n_err++;
            $display("FAIL %s ready class: got mul=%b div=%b, want div class=%b",
                     name, mul_ready, div_ready, e.is_div);
          end
          n_cmp++;
          if ((e.is_div ? divres : mulres) !== e.res) begin
            n_err++;
            $display("FAIL %s result: got %h, want %h", name, e.is_div ? divres : mulres, e.res);
          end
          if (e.is_div) exp_divres = e.res;
          else          exp_mulres = e.res;
        end
        rdy++;
        if (!hold) done = 1'b1;
      end
      @(posedge clk); #1;
      if (done) break;
    end
    issue_valid = 1'b0; hold = 1'b0;
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL %s timeout: got no ready release, want release by cycle %0d", name, exp_lat);
    end
    n_cmp++;
    if (starts !== exp_starts || steps !== exp_steps || rdy !== exp_rdy) begin
      n_err++;
      $display("FAIL %s pulses: got start=%0d step=%0d rdy=%0d, want %0d/%0d/%0d",
               name, starts, steps, rdy, exp_starts, exp_steps, exp_rdy);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b0; hold = 0; kill = 0; issue_valid = 0; issue_is_div = 0;
    issue_funct3 = '0; issue_rs1 = '0; issue_rs2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({dp_start, dp_step, dp_is_div, dp_funct3, mul_ready, div_ready, busy} !== 9'b0 ||
        dp_a !== 32'd0 || dp_b !== 32'd0 || mulres !== 32'd0 || divres !== 32'd0) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b start=%b step=%b mulres=%h divres=%h dp_a=%h, want all zero",
               busy, dp_start, dp_step, mulres, divres, dp_a);
    end
    @(posedge clk); #1;
    Rst = 1'b1;
  endtask

  task automatic test_mul();
    int s;
    run_op("mul_7x6", 1'b0, MUL, 32'd7, 32'd6, 32'd42, 0, 0, N + 1, 1, N, 1, s);
    run_op("mulh_neg", 1'b0, MULH, 32'hFFFF_FFFE, 32'd3,
           ref_calc(1'b0, MULH, 32'hFFFF_FFFE, 32'd3), 0, 0, N + 1, 1, N, 1, s);
    run_op("mulhu", 1'b0, MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0, N + 1, 1, N, 1, s);
  endtask

  task automatic test_special();
    int s;
    run_op("divu_by0", 1'b1, DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 0, 0, 1, 0, 0, 1, s);
    run_op("rem_ovf", 1'b1, REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 0, 1, 0, 0, 1, s);
    run_op("div_ovf", 1'b1, DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 1, 0, 0, 1, s);
    run_op("remu_by0", 1'b1, REMU, 32'd5, 32'd0, 32'd5, 0, 0, 1, 0, 0, 1, s);
  endtask

  task automatic test_div();
    int s;
    run_op("div_neg", 1'b1, DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 0, 0, N + 1, 1, N, 1, s);
    run_op("divu_big", 1'b1, DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 0, N + 1, 1, N, 1, s);
  endtask

  task automatic test_hold();
    int s;
    run_op("hold_run", 1'b0, MUL, 32'd9, 32'd9, 32'd81, 10, 3, N + 4, 1, N, 1, s);
    run_op("hold_done", 1'b1, REMU, 32'd17, 32'd5, 32'd2, N + 1, 2, N + 1, 1, N, 3, s);
  endtask

  task automatic test_kill();
    int starts = 0, rdy = 0;
    issue_valid = 1'b1; issue_is_div = 1'b0; issue_funct3 = MUL;
    issue_rs1 = 32'd3; issue_rs2 = 32'd5;
    for (int c = 0; c < 50; c++) begin
      kill = (c == 10);
      if (c == 10) issue_valid = 1'b0;
      @(negedge clk);
      starts += int'(dp_start);
      rdy    += int'(mul_ready | div_ready);
      if (c == 11) begin
        n_cmp++;
        if (busy !== 1'b0) begin
          n_err++;
          $display("FAIL kill_idle: got busy=%b, want 0", busy);
        end
      end
      @(posedge clk); #1;
    end
    kill = 1'b0;
    n_cmp++;
    if (rdy !== 0 || starts !== 1 || mulres !== exp_mulres) begin
      n_err++;
      $display("FAIL kill_run: got rdy=%0d starts=%0d mulres=%h, want 0/1/%h",
               rdy, starts, mulres, exp_mulres);
    end
    issue_valid = 1'b1; issue_is_div = 1'b1; issue_funct3 = DIV;
    issue_rs1 = 32'd50; issue_rs2 = 32'd5; kill = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (dp_start !== 1'b0) begin
      n_err++;
      $display("FAIL kill_issue_start: got dp_start=%b, want 0", dp_start);
    end
    @(posedge clk); #1;
    issue_valid = 1'b0; kill = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || divres !== exp_divres) begin
      n_err++;
      $display("FAIL kill_issue_state: got busy=%b divres=%h, want 0/%h", busy, divres, exp_divres);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int s1, s2;
    run_op("b2b_mul", 1'b0, MULHSU, 32'hFFFF_FFFF, 32'd2,
           ref_calc(1'b0, MULHSU, 32'hFFFF_FFFF, 32'd2), 0, 0, N + 1, 1, N, 1, s1);
    run_op("b2b_div", 1'b1, DIV, 32'd1000, 32'd7, 32'd142, 0, 0, N + 1, 1, N, 1, s2);
    n_cmp++;
    if (s1 + s2 !== 2) begin
      n_err++;
      $display("FAIL b2b_starts: got %0d, want 2", s1 + s2);
    end
  endtask

  task automatic test_reset_mid_run();
    issue_valid = 1'b1; issue_is_div = 1'b1; issue_funct3 = DIVU;
    issue_rs1 = 32'd1000; issue_rs2 = 32'd3;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) begin
        Rst = 1'b0; issue_valid = 1'b0; issue_is_div = 1'b0; issue_funct3 = '0;
      end
      @(posedge clk); #1;
    end
    Rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({dp_start, dp_step, dp_is_div, mul_ready, div_ready, busy} !== 6'b0 ||
        mulres !== 32'd0 || divres !== 32'd0 || dp_a !== 32'd0 || dp_b !== 32'd0) begin
      n_err++;
      $display("FAIL reset_mid_run: got busy=%b step=%b mulres=%h divres=%h dp_a=%h, want all zero",
               busy, dp_step, mulres, divres, dp_a);
    end
    exp_mulres = '0; exp_divres = '0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_special();
    test_div();
    test_hold();
    test_kill();
    test_back_to_back();
    test_reset_mid_run();
    n_cmp++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
